// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/result handshake bundle for the immediate encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Value;
    logic [1:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] Instr;
    logic        Fail;
    modport master (output in_valid, Value, ImmSrc, out_ready, input in_ready, out_valid, Instr, Fail);
    modport slave  (input in_valid, Value, ImmSrc, out_ready, output in_ready, out_valid, Instr, Fail);
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: turns a 32-bit constant plus ImmSrc class into the 24-bit immediate field;
// DP constants are searched one rotation per cycle.
module imm_encoder (
    input  logic         clk,
    input  logic         reset_n,
    imm_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  src_q, src_d;
    logic [23:0] instr_q, instr_d;
    logic        fail_q, fail_d, valid_q, valid_d;
    logic        dp_hit, mem_ok, b_ok;
    assign dp_hit = w_q[31:8] == 24'd0;
    assign mem_ok = w_q[31:12] == 20'd0;
    assign b_ok   = w_q[1:0] == 2'b00 && (&w_q[31:25] || ~|w_q[31:25]);
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        instr_d = instr_q;
        fail_d  = fail_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                w_d     = bus.Value;
                src_d   = bus.ImmSrc;
                cnt_d   = 4'd0;
                state_d = SEARCH;
            end
            SEARCH: if (src_q == 2'b00 && !dp_hit && cnt_q != 4'd15) begin
                // W keeps the invariant Value == W[7:0] ROR (2*cnt)
                w_d   = {w_q[29:0], w_q[31:30]};
                cnt_d = cnt_q + 4'd1;
            end else begin
                state_d = DONE;
                valid_d = 1'b1;
                case (src_q)
                    2'b00:   begin fail_d = !dp_hit;  instr_d = dp_hit ? {12'd0, cnt_q, w_q[7:0]} : 24'd0; end
                    2'b01:   begin fail_d = !mem_ok;  instr_d = mem_ok ? {12'd0, w_q[11:0]} : 24'd0; end
                    2'b10:   begin fail_d = !b_ok;    instr_d = b_ok ? w_q[25:2] : 24'd0; end
                    default: begin fail_d = 1'b1;     instr_d = 24'd0; end
                endcase
            end
            DONE: if (bus.out_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            src_q   <= '0;
            instr_q <= '0;
            fail_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            instr_q <= instr_d;
            fail_q  <= fail_d;
            valid_q <= valid_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = valid_q;
    assign bus.Instr     = instr_q;
    assign bus.Fail      = fail_q;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against a rule-level model.
module tb_imm_encoder;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    imm_encoder_if bus ();
    imm_encoder dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: smallest rotation r with Value == imm8 ROR 2r, plain range tests otherwise
    task automatic model(input logic [31:0] v, input logic [1:0] s,
                         output logic [23:0] instr, output logic fail, output int lat);
        logic [63:0] t;
        int sv;
        instr = 24'd0; fail = 1'b1; lat = 1;
        case (s)
            2'b00: begin
                lat = 16;
                for (int r = 0; r < 16; r++) begin
                    t = {v, v} << (2 * r);
                    if (fail && t[63:32] < 32'd256) begin
                        fail = 1'b0;
                        lat = r + 1;
                        instr = (r << 8) | t[39:32];
                    end
                end
            end
            2'b01: if (v < 32'd4096) begin fail = 1'b0; instr = v[23:0]; end
            2'b10: begin
                sv = v;
                if (sv >= -(1 << 25) && sv < (1 << 25) && v % 4 == 0) begin
                    fail = 1'b0;
                    instr = v[25:2];
                end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [31:0] v, input logic [1:0] s);
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1; bus.Value = v; bus.ImmSrc = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.Value = $urandom; bus.ImmSrc = 2'($urandom);
    endtask

    task automatic request(input string tag, input logic [31:0] v, input logic [1:0] s, input int hold);
        logic [23:0] ei, si;
        logic ef, sf;
        int el, lat;
        model(v, s, ei, ef, el);
        issue(v, s);
        chk({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            bus.Value = $urandom;
            lat++;
        end while (!bus.out_valid && lat < 40);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_instr"}, {8'd0, bus.Instr}, {8'd0, ei});
        chk({tag, "_fail"}, {31'd0, bus.Fail}, {31'd0, ef});
        si = bus.Instr; sf = bus.Fail;
        for (int i = 0; i < hold; i++) @(posedge clk);
        if (hold > 0) begin
            #1;
            chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({tag, "_hold_instr"}, {8'd0, bus.Instr}, {8'd0, si});
            chk({tag, "_hold_fail"}, {31'd0, bus.Fail}, {31'd0, sf});
            chk({tag, "_hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        chk({tag, "_drop_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic [1:0] s;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.Value = '0; bus.ImmSrc = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_instr", {8'd0, bus.Instr}, 32'd0);
        chk("rst_fail", {31'd0, bus.Fail}, 32'd0);
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        request("dp_ab", 32'h0000_00AB, 2'b00, 0);
        request("dp_ff_rot4", 32'hFF00_0000, 2'b00, 5);
        request("dp_wrap", 32'hF000_000F, 2'b00, 0);
        request("dp_101", 32'h0000_0101, 2'b00, 0);
        request("dp_zero", 32'h0000_0000, 2'b00, 0);
        request("mem_fff", 32'h0000_0FFF, 2'b01, 0);
        request("mem_1000", 32'h0000_1000, 2'b01, 0);
        request("b_neg4", 32'hFFFF_FFFC, 2'b10, 0);
        request("b_max", 32'h01FF_FFFC, 2'b10, 0);
        request("b_over", 32'h0200_0000, 2'b10, 0);
        request("b_misal", 32'h0000_0002, 2'b10, 0);
        request("rsvd", 32'h0000_0004, 2'b11, 0);
        bus.out_ready = 1'b1;
        request("rdy_early", 32'h0000_0030, 2'b00, 0);
        bus.out_ready = 1'b0;
        issue(32'h0000_0101, 2'b00);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_fail", {31'd0, bus.Fail}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        request("mem_123", 32'h0000_0123, 2'b01, 0);
        for (int i = 0; i < 80; i++) begin
            s = 2'($urandom_range(0, 3));
            v = $urandom;
            case ($urandom_range(0, 2))
                0: ;
                1: begin
                    v = 32'($urandom_range(0, 255));
                    v = ({v, v} >> (2 * $urandom_range(0, 15))) & 64'hFFFF_FFFF;
                end
                default: v = s == 2'b01 ? v & 32'h0000_1FFF : {{7{v[31]}}, v[24:2], 2'b00};
            endcase
            request($sformatf("rnd%0d", i), v, s, $urandom_range(0, 2));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
# imm_encoder

- Sequential inverse of the immediate extender: converts a 32-bit constant plus an `ImmSrc` class into the 24-bit instruction immediate field the extender expands back into that same constant.
- Flags constants that have no encoding.
- Used by the self-test instruction generator and by the boot-ROM patch path to build instruction words in hardware.
- Data-processing (DP) immediates use full ARM rotated form, searched one rotation per cycle.

## Interface
- No parameters.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`; high only in IDLE.
- `Value`  in  32  constant to encode.
- `ImmSrc`  in  2  encoding class:
  - 00 DP
  - 01 MEM
  - 10 B
  - 11 reserved
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `Instr`  out  24  encoded immediate field.
- `Fail`  out  1  no legal encoding exists; `Instr` = 0 when set.

## Operation
- States:
  - IDLE: `in_ready`=1. On accept, latch `Value` into working register W and latch `ImmSrc`; clear rotation counter `cnt`(4b); go to SEARCH.
  - SEARCH: evaluate the latched class every cycle, as below.
  - DONE: `out_valid`=1. `Instr` and `Fail` are held stable. On `out_ready`, go to IDLE.
- DP (`ImmSrc`=00):
  - Each SEARCH cycle tests W[31:8]==0.
  - Hit: `Instr`={12'b0, cnt, W[7:0]}, `Fail`=0, go to DONE.
  - Miss with `cnt`<15: W ← W rotated left by 2, `cnt` ← `cnt`+1.
  - Miss with `cnt`==15: `Fail`=1, `Instr`=0, go to DONE.
  - Invariant: `Value` == W[7:0] ROR (2·`cnt`).
  - The smallest `cnt` wins, so any value < 256 encodes with rot=0, bit-compatible with the zero-extending DP extender.
- MEM (01): single SEARCH cycle.
  - Legal iff `Value`[31:12]==0.
  - `Instr`={12'b0, `Value`[11:0]}.
- B (10): single SEARCH cycle.
  - Legal iff `Value`[1:0]==0 and `Value`[31:25] is all-equal, i.e. the value sign-fits in 26 bits.
  - `Instr`=`Value`[25:2].
  - Round-trip requirement: {{6{`Instr`[23]}}, `Instr`, 2'b00} == `Value`.
- Reserved (11): single SEARCH cycle, `Fail`=1.
- Inputs are sampled only at accept. Changes to `Value`/`ImmSrc` while busy are ignored.
- `in_valid` is ignored outside IDLE. There is no queueing; one request is in flight at a time.

## Timing
- Reset (async, immediate):
  - state=IDLE, `out_valid`=0, `Instr`=0, `Fail`=0, W=0, `cnt`=0.
  - `in_ready`=1 while idle, including during reset.
- Reset asserted mid-SEARCH or in DONE aborts the request; the result is lost.
- `out_valid`, `Instr` and `Fail` are registered. `in_ready` is decoded from state.
- Latency, in edges from the accept edge to the edge that raises `out_valid`:
  - MEM, B, reserved: 1.
  - DP hit at rotation k: k+1.
  - DP fail: 16.
- DONE→IDLE on the `out_ready` edge. `out_valid` drops and `in_ready` rises in the same cycle.
- Next accept happens on the following edge at the earliest. Minimum issue interval is latency+2 cycles.
- Backpressure: `out_valid` stays high and outputs stay stable for any number of cycles with `out_ready`=0.
- `out_ready` high while not in DONE has no effect.

## Test plan
- DP `Value`=0x000000AB → `Instr`=0x0000AB, `Fail`=0, `out_valid` 1 edge after accept.
- DP `Value`=0xFF000000 → `Instr`=0x0004FF (rot 4, latency 5). DP 0xF000000F (wrap-around) → `Instr`=0x0002FF (latency 3).
- DP `Value`=0x00000101 → `Fail`=1, `Instr`=0, latency 16. DP 0x00000000 → `Instr`=0x000000, latency 1.
- MEM 0x00000FFF → `Instr`=0x000FFF. MEM 0x00001000 → `Fail`=1.
- B cases, each with latency 1:
  - 0xFFFFFFFC → `Instr`=0xFFFFFF.
  - 0x01FFFFFC → `Instr`=0x7FFFFF.
  - 0x02000000 → `Fail`.
  - 0x00000002 → `Fail`.
  - `ImmSrc`=11 → `Fail`.
- Control and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable and `in_ready`=0.
  - Toggle `Value` during SEARCH → result unchanged.
  - Drop `reset_n` on the 4th SEARCH cycle of DP 0x101 → `out_valid`=0 at once, `in_ready`=1.
  - After release, a new MEM 0x123 request returns 0x000123.
